regfile_write_arbiter: RTL

Shares the register file's single write port between two writeback sources: the ALU result path (source A) and the load-data path from data memory (source B). Each source hands over a destination register and 32-bit data with a valid/ready handshake, and the block holds it in a one-entry slot per source. The block issues at most one write per cycle to the register file, oldest entry first, and discards writes to x0. It sits between the execute/memory stages and the register file write inputs (writeReg, writeData, RegWrite).

---
 rtl/regfile_write_arbiter_if.sv | 28 ++
 rtl/regfile_write_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Write-arbiter bus: two writeback sources (A = ALU, B = load) on one side,
// register file write port plus status on the other.
interface regfile_write_arbiter_if;
    logic        aValid;
    logic [4:0]  aReg;
    logic [31:0] aData;
    logic        aReady;
    logic        bValid;
    logic [4:0]  bReg;
    logic [31:0] bData;
    logic        bReady;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        RegWrite;
    logic        idle;

    // Writeback sources and register file side
    modport master (
        output aValid, aReg, aData, bValid, bReg, bData,
        input  aReady, bReady, writeReg, writeData, RegWrite, idle
    );

    // Arbiter side
    modport slave (
        input  aValid, aReg, aData, bValid, bReg, bData,
        output aReady, bReady, writeReg, writeData, RegWrite, idle
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: one-entry slot per source (ALU = A,
// load = B), oldest entry issued first, writes to x0 dropped at the handshake.
// Optional feature macro: WRARB_STATS_EN adds saturating writeCount and
// conflictCount outputs.
module regfile_write_arbiter (
    input  logic                   CLK,
    input  logic                   RESET,
    regfile_write_arbiter_if.slave bus
`ifdef WRARB_STATS_EN
    ,
    output logic [15:0]            writeCount,
    output logic [15:0]            conflictCount
`endif
);

    logic        aFull_q, aFull_d;
    logic        bFull_q, bFull_d;
    logic [4:0]  aReg_q, aReg_d;
    logic [4:0]  bReg_q, bReg_d;
    logic [31:0] aData_q, aData_d;
    logic [31:0] bData_q, bData_d;
    logic        olderIsA_q, olderIsA_d;
    logic [4:0]  writeReg_q, writeReg_d;
    logic [31:0] writeData_q, writeData_d;
    logic        RegWrite_q, RegWrite_d;

    logic        grantA, grantB;
    logic        capA, capB;

    // Arbitration and handshake from registered slot state
    always_comb begin
        grantA = aFull_q && (!bFull_q || olderIsA_q);
        grantB = bFull_q && (!aFull_q || !olderIsA_q);
        bus.aReady = !aFull_q || grantA;
        bus.bReady = !bFull_q || grantB;
        capA = bus.aValid && bus.aReady && (bus.aReg != 5'd0);
        capB = bus.bValid && bus.bReady && (bus.bReg != 5'd0);
        bus.writeReg  = writeReg_q;
        bus.writeData = writeData_q;
        bus.RegWrite  = RegWrite_q;
        bus.idle      = !aFull_q && !bFull_q && !RegWrite_q;
    end

    // Slot occupancy, capture/reload, age tracking and issue next-state
    always_comb begin
        aFull_d     = aFull_q;
        bFull_d     = bFull_q;
        aReg_d      = aReg_q;
        bReg_d      = bReg_q;
        aData_d     = aData_q;
        bData_d     = bData_q;
        writeReg_d  = writeReg_q;
        writeData_d = writeData_q;
        RegWrite_d  = 1'b0;

        if (grantA) begin
            aFull_d     = 1'b0;
            writeReg_d  = aReg_q;
            writeData_d = aData_q;
            RegWrite_d  = 1'b1;
        end else if (grantB) begin
            bFull_d     = 1'b0;
            writeReg_d  = bReg_q;
            writeData_d = bData_q;
            RegWrite_d  = 1'b1;
        end

        if (capA) begin
            aFull_d = 1'b1;
            aReg_d  = bus.aReg;
            aData_d = bus.aData;
        end
        if (capB) begin
            bFull_d = 1'b1;
            bReg_d  = bus.bReg;
            bData_d = bus.bData;
        end

        // A slot that is full afterwards without a capture was never granted,
        // so "untouched" reduces to "not captured this edge".
        if (aFull_d && bFull_d) begin
            if (capA && capB)
                olderIsA_d = 1'b0;
            else if (capA)
                olderIsA_d = 1'b0;
            else if (capB)
                olderIsA_d = 1'b1;
            else
                olderIsA_d = olderIsA_q;
        end else begin
            olderIsA_d = aFull_d;
        end
    end

    // State registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            aFull_q     <= 1'b0;
            bFull_q     <= 1'b0;
            aReg_q      <= '0;
            bReg_q      <= '0;
            aData_q     <= '0;
            bData_q     <= '0;
            olderIsA_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
            RegWrite_q  <= 1'b0;
        end else begin
            aFull_q     <= aFull_d;
            bFull_q     <= bFull_d;
            aReg_q      <= aReg_d;
            bReg_q      <= bReg_d;
            aData_q     <= aData_d;
            bData_q     <= bData_d;
            olderIsA_q  <= olderIsA_d;
            writeReg_q  <= writeReg_d;
            writeData_q <= writeData_d;
            RegWrite_q  <= RegWrite_d;
        end
    end

`ifdef WRARB_STATS_EN
    logic [15:0] writeCount_q, conflictCount_q;

    // Saturating counters: issued-write cycles and both-slots-full cycles
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            writeCount_q    <= '0;
            conflictCount_q <= '0;
        end else begin
            if (RegWrite_q && (writeCount_q != 16'hFFFF))
                writeCount_q <= writeCount_q + 16'd1;
            if (aFull_q && bFull_q && (conflictCount_q != 16'hFFFF))
                conflictCount_q <= conflictCount_q + 16'd1;
        end
    end

    assign writeCount    = writeCount_q;
    assign conflictCount = conflictCount_q;
`endif

endmodule
